// File: rtl/pe_defs.sv
// Shared constants for the PE group sequencer: reset level, PE process codes,
// default widths and the controller state encoding.
package pe_defs;

  localparam logic       RST_ENABLE = 1'b0;

  localparam logic [2:0] PROC_IDLE  = 3'd0;
  localparam logic [2:0] PROC_START = 3'd1;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_SUM_W  = 11;
  localparam int DEF_LAT    = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/pe_addr_gen.sv
// Address walker: loads a base and clears its count, then adds step per advance.
// addr always equals base + cnt*step, wrapping at 2^ADDR_W.
module pe_addr_gen
  import pe_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        step,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] cnt
);

  logic [ADDR_W-1:0] step_ext;
  assign step_ext = {{(ADDR_W-3){1'b0}}, step};

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= base;
      cnt  <= '0;
    end else if (adv) begin
      addr <= addr + step_ext;
      cnt  <= cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pe_group_ctrl.sv
// Job sequencer for one 5-tap PE group: streams ifmap window addresses, holds the
// PE pipeline alive with finish_flag until every result is written, then pulses done.
module pe_group_ctrl
  import pe_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SUM_W  = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        layer,
  input  logic [ADDR_W-1:0] num_out,
  input  logic [2:0]        stride,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [ADDR_W-1:0] ofmap_base,
  output logic [ADDR_W-1:0] ifmap_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [2:0]        pe_process,
  output logic              pe_finish_flag,
  output logic [3:0]        pe_layer,
  input  logic              pe_wb_en,
  input  logic [SUM_W-1:0]  pe_sum,
  output logic              ofm_we,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic [SUM_W-1:0]  ofm_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state, nxt_state;
  logic [ADDR_W-1:0] num_q, iss_cnt, wr_cnt;
  logic [2:0]        stride_q;
  logic              load, iss_adv, last_iss, last_wr;

  assign load     = (state == ST_IDLE) && start && !abort;
  assign iss_adv  = (state == ST_RUN);
  assign last_iss = (iss_cnt == num_q - ONE);
  assign ofm_we   = pe_wb_en && ((state == ST_RUN) || (state == ST_DRAIN)) && (wr_cnt < num_q);
  assign last_wr  = ofm_we && (wr_cnt == num_q - ONE);

  assign ofm_data       = ofm_we ? pe_sum : '0;
  assign pe_finish_flag = (state == ST_DRAIN);
  assign busy           = (state == ST_RUN) || (state == ST_DRAIN);
  assign done           = (state == ST_DONE);

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:  if (start) nxt_state = (num_out == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_iss) nxt_state = ST_DRAIN;
      ST_DRAIN: if ((wr_cnt == num_q) || last_wr) nxt_state = ST_DONE;
      default:  nxt_state = ST_IDLE;
    endcase
    if (abort) nxt_state = ST_IDLE;
  end

  // pe_process lags the issue by one cycle so it lines up with bank read data
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= ST_IDLE;
      num_q      <= '0;
      stride_q   <= '0;
      wgt_addr   <= '0;
      pe_layer   <= '0;
      pe_process <= PROC_IDLE;
    end else begin
      state      <= nxt_state;
      pe_process <= (iss_adv && !abort) ? PROC_START : PROC_IDLE;
      if (load) begin
        num_q    <= num_out;
        stride_q <= (stride == 3'd0) ? 3'd1 : stride;
        wgt_addr <= wgt_base;
        pe_layer <= layer;
      end
    end
  end

  pe_addr_gen #(.ADDR_W(ADDR_W)) u_ifm_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .adv  (iss_adv),
    .base (ifmap_base),
    .step (stride_q),
    .addr (ifmap_addr),
    .cnt  (iss_cnt)
  );

  pe_addr_gen #(.ADDR_W(ADDR_W)) u_ofm_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .adv  (ofm_we),
    .base (ofmap_base),
    .step (3'd1),
    .addr (ofm_addr),
    .cnt  (wr_cnt)
  );

endmodule

// File: tb/tb_pe_group_ctrl.sv
// Directed bench for pe_group_ctrl with a 3-cycle PE model fed by a 1-cycle ifmap bank.
`timescale 1ns/1ps
module tb_pe_group_ctrl;
  localparam int AW = 10;
  localparam int SW = 11;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0]    layer = '0;
  logic [AW-1:0] num_out = '0, ifmap_base = '0, wgt_base = '0, ofmap_base = '0;
  logic [2:0]    stride = '0;
  logic [AW-1:0] ifmap_addr, wgt_addr, ofm_addr;
  logic [2:0]    pe_process;
  logic          pe_finish_flag, ofm_we, busy, done, pe_wb_en;
  logic [3:0]    pe_layer;
  logic [SW-1:0] pe_sum, ofm_data;

  int n_vec = 0, n_miss = 0;
  int r_ifa[40], r_we[40], r_oa[40], r_od[40], r_proc[40], r_flag[40], r_busy[40], r_done[40];
  int r_wgt[40], r_layer[40];

  always #5 clk = ~clk;

  pe_group_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .layer(layer),
    .num_out(num_out), .stride(stride), .ifmap_base(ifmap_base), .wgt_base(wgt_base),
    .ofmap_base(ofmap_base), .ifmap_addr(ifmap_addr), .wgt_addr(wgt_addr),
    .pe_process(pe_process), .pe_finish_flag(pe_finish_flag), .pe_layer(pe_layer),
    .pe_wb_en(pe_wb_en), .pe_sum(pe_sum), .ofm_we(ofm_we), .ofm_addr(ofm_addr),
    .ofm_data(ofm_data), .busy(busy), .done(done)
  );

  // PE model: bank read 1 cycle, then 3 stages; sum = 3*addr+1; 'extra' stretches wb_en
  logic [AW-1:0] rd_q = '0;
  logic [4:0]    pv = '0;
  logic [SW-1:0] pd[5];
  logic          extra = 1'b0;
  initial foreach (pd[i]) pd[i] = '0;
  always @(posedge clk) begin
    rd_q  <= ifmap_addr;
    pv    <= {pv[3:0], pe_process == 3'd1};
    pd[0] <= {1'b0, rd_q} * 11'd3 + 11'd1;
    for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
  end
  assign pe_wb_en = pv[2] | (extra & (pv[3] | pv[4]));
  assign pe_sum   = pv[2] ? pd[2] : 11'h7ff;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start must already be set up for cycle 0; records cycles 1..ncyc
  task automatic run_job(input int ncyc, input int abort_at, input int restart_at,
                         input int midstart_at, input int rst_at);
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      r_ifa[c] = ifmap_addr;   r_we[c] = ofm_we;        r_oa[c] = ofm_addr;
      r_od[c] = ofm_data;      r_proc[c] = pe_process;  r_flag[c] = pe_finish_flag;
      r_busy[c] = busy;        r_done[c] = done;        r_wgt[c] = wgt_addr;
      r_layer[c] = pe_layer;
      start = (c == restart_at) || (c == midstart_at);
      abort = (c == abort_at);
      if (c == restart_at) begin
        num_out = 2; stride = 1; ifmap_base = 20; ofmap_base = 200;
      end
      if (c == midstart_at) ifmap_base = 500;
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst flag", pe_finish_flag, 0);
        chk("rst proc", pe_process, 0);
        chk("rst ifa", ifmap_addr, 0);
        chk("rst wgt", wgt_addr, 0);
        chk("rst oa", ofm_addr, 0);
        chk("rst we", ofm_we, 0);
        chk("rst done", done, 0);
        rst = 1'b1;
      end
      tick();
    end
  endtask

  task automatic chk_job(input string nm, input int n, input int s, input int ib, input int ob,
                         input int c0, input int clast);
    int done_c;
    done_c = (n == 0) ? c0 + 1 : c0 + n + 5;
    for (int c = c0 + 1; c <= clast; c++) begin
      int we_e, j;
      we_e = (n > 0 && c >= c0 + 5 && c <= c0 + n + 4);
      chk($sformatf("%s we@%0d", nm, c), r_we[c], we_e);
      if (we_e != 0) begin
        j = c - c0 - 5;
        chk($sformatf("%s oa@%0d", nm, c), r_oa[c], (ob + j) % 1024);
        chk($sformatf("%s od@%0d", nm, c), r_od[c], ((((ib + j * s) % 1024) * 3) + 1) % 2048);
      end
      chk($sformatf("%s done@%0d", nm, c), r_done[c], int'(c == done_c));
      chk($sformatf("%s busy@%0d", nm, c), r_busy[c], int'(n > 0 && c <= c0 + n + 4));
      chk($sformatf("%s flag@%0d", nm, c), r_flag[c], int'(n > 0 && c >= c0 + n + 1 && c <= c0 + n + 4));
      chk($sformatf("%s proc@%0d", nm, c), r_proc[c], int'(n > 0 && c >= c0 + 2 && c <= c0 + n + 1));
      if (c <= c0 + n)
        chk($sformatf("%s ifa@%0d", nm, c), r_ifa[c], (ib + (c - c0 - 1) * s) % 1024);
    end
  endtask

  task automatic setup(input int n, input int s, input int ib, input int ob, input int w, input int ly);
    num_out = AW'(n); stride = 3'(s); ifmap_base = AW'(ib); ofmap_base = AW'(ob);
    wgt_base = AW'(w); layer = 4'(ly); start = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset proc", pe_process, 0);
    chk("reset flag", pe_finish_flag, 0);
    chk("reset ifa", ifmap_addr, 0);
    chk("reset wgt", wgt_addr, 0);
    chk("reset we", ofm_we, 0);
    chk("reset layer", pe_layer, 0);
    rst = 1'b1;
    repeat (2) tick();

    setup(4, 1, 10, 100, 55, 5);
    run_job(11, -1, -1, -1, -1);
    chk_job("basic", 4, 1, 10, 100, 0, 11);
    chk("basic wgt", r_wgt[3], 55);
    chk("basic layer", r_layer[3], 5);
    repeat (4) tick();

    extra = 1'b1;
    setup(4, 1, 40, 300, 1, 2);
    run_job(12, -1, -1, -1, -1);
    chk_job("drain", 4, 1, 40, 300, 0, 12);
    repeat (4) tick();
    extra = 1'b0;

    setup(3, 2, 1022, 1023, 7, 1);
    run_job(10, -1, -1, -1, -1);
    chk_job("wrap", 3, 2, 1022, 1023, 0, 10);
    repeat (4) tick();

    setup(2, 0, 5, 7, 3, 3);
    run_job(9, -1, -1, -1, -1);
    chk_job("stride0", 2, 1, 5, 7, 0, 9);
    repeat (4) tick();

    setup(0, 1, 5, 7, 3, 3);
    run_job(4, -1, -1, -1, -1);
    chk_job("zero", 0, 1, 5, 7, 0, 4);
    repeat (4) tick();

    setup(8, 1, 60, 400, 9, 4);
    run_job(15, 3, 6, -1, -1);
    chk_job("abort", 8, 1, 60, 400, 0, 3);
    chk("abort busy@4", r_busy[4], 0);
    chk("abort proc@4", r_proc[4], 0);
    for (int c = 4; c <= 10; c++) begin
      chk($sformatf("abort we@%0d", c), r_we[c], 0);
      chk($sformatf("abort done@%0d", c), r_done[c], 0);
    end
    chk_job("restart", 2, 1, 20, 200, 6, 15);
    repeat (6) tick();

    setup(4, 1, 10, 100, 55, 5);
    run_job(6, -1, -1, 2, 6);
    chk_job("busystart", 4, 1, 10, 100, 0, 6);
    repeat (6) tick();

    setup(1, 1, 3, 9, 11, 6);
    run_job(7, -1, -1, -1, -1);
    chk_job("postrst", 1, 1, 3, 9, 0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
